// File: rtl/un_byte_striping_n_pkg.sv
// Shared definitions for the byte-striping successors: FSM encodings,
// a constant-safe clog2 and the default link geometry.
package un_byte_striping_n_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_LANES = 4;
   localparam int DEF_DEPTH = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/ubs_round_fifo.sv
// Round buffer: DEPTH entries, each holding one full lane round plus its
// word count. Push is ignored when full, pop is ignored when empty.
module ubs_round_fifo
   import un_byte_striping_n_pkg::*;
#(
   parameter int DW    = 8,
   parameter int DEPTH = 2,
   localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1,
   localparam int CNT_W = clog2(DEPTH + 1)
) (
   input  logic             clk_f,
   input  logic             reset_L,
   input  logic             push,
   input  logic             pop,
   input  logic [DW-1:0]    din,
   output logic [DW-1:0]    dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [DW-1:0]    mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      push_ok  = push && !full;
      pop_ok   = pop && !empty;
      wr_ptr_d = push_ok ? ptr_next(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop_ok ? ptr_next(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
      else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
   end

   // NOTE: storage has no reset; the count and pointers alone decide
   // which entries are meaningful, so flushing them is enough.
   always_ff @(posedge clk_f) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end

   always_ff @(posedge clk_f or negedge reset_L) begin
      if (!reset_L) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/un_byte_striping_n.sv
// Lane unstriper: buffers rounds of LANES parallel words and replays them
// as a serial stream in lane order, honouring downstream backpressure.
module un_byte_striping_n
   import un_byte_striping_n_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int LANES = DEF_LANES,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                   clk_f,
   input  logic                   reset_L,
   input  logic [LANES*WIDTH-1:0] lane_data,
   input  logic [LANES-1:0]       lane_valid,
   output logic                   in_ready,
   output logic [WIDTH-1:0]       data_out,
   output logic                   valid_out,
   input  logic                   out_ready,
   output logic                   err_lane
);

   localparam int IDX_W = clog2(LANES);
   localparam int NW_W  = IDX_W + 1;
   localparam int DW    = LANES * WIDTH;
   localparam int EW    = DW + NW_W;
   localparam int CNT_W = clog2(DEPTH + 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic               valid_q, valid_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               err_q, err_d;

   logic [LANES-1:0]   lv_plus1;
   logic               contig, offer, push, pop, load, drained;
   logic [NW_W-1:0]    nwords_in;
   logic [EW-1:0]      fifo_head;
   logic [DW-1:0]      head_data;
   logic [NW_W-1:0]    head_nwords;
   logic               fifo_full, fifo_empty;
   logic [CNT_W-1:0]   fifo_count;

   ubs_round_fifo #(.DW(EW), .DEPTH(DEPTH)) u_fifo (
      .clk_f   (clk_f),
      .reset_L (reset_L),
      .push    (push),
      .pop     (pop),
      .din     ({nwords_in, lane_data}),
      .dout    (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign in_ready    = !fifo_full;
   assign head_data   = fifo_head[DW-1:0];
   assign head_nwords = fifo_head[EW-1 -: NW_W];

   // A valid mask of the form 2^k-1 has no bit in common with itself plus one.
   always_comb begin
      lv_plus1  = lane_valid + LANES'(1);
      contig    = (lane_valid & lv_plus1) == '0;
      nwords_in = '0;
      for (int i = 0; i < LANES; i++) nwords_in = nwords_in + NW_W'(lane_valid[i]);
      offer = in_ready && (lane_valid != '0);
      push  = offer && contig;
      err_d = err_q | (offer && !contig);
   end

   // NOTE: every output of this block is given a default first, so no
   // path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      idx_d   = idx_q;
      pop     = 1'b0;
      load    = !valid_q || out_ready;
      if (load) begin
         if (!fifo_empty) begin
            data_d  = head_data[idx_q*WIDTH +: WIDTH];
            valid_d = 1'b1;
            if ({1'b0, idx_q} == head_nwords - NW_W'(1)) begin
               pop   = 1'b1;
               idx_d = '0;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end else begin
            valid_d = 1'b0;
         end
      end

      drained = pop && (fifo_count == CNT_W'(1)) && !push;
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (load && !fifo_empty && !drained) state_d = ST_SEND;
         ST_SEND: if (drained) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_f or negedge reset_L) begin
      if (!reset_L) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         valid_q <= 1'b0;
         idx_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
      end
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign err_lane  = err_q;

endmodule

// File: tb/tb_un_byte_striping_n.sv
// Directed bench for un_byte_striping_n at LANES=4, WIDTH=32, DEPTH=2.
module tb_un_byte_striping_n;

   logic          clk_f = 1'b0;
   logic          reset_L;
   logic [127:0]  lane_data;
   logic [3:0]    lane_valid;
   logic          in_ready;
   logic [31:0]   data_out;
   logic          valid_out;
   logic          out_ready;
   logic          err_lane;

   int vectors     = 0;
   int miscompares = 0;

   un_byte_striping_n #(.WIDTH(32), .LANES(4), .DEPTH(2)) dut (
      .clk_f      (clk_f),
      .reset_L    (reset_L),
      .lane_data  (lane_data),
      .lane_valid (lane_valid),
      .in_ready   (in_ready),
      .data_out   (data_out),
      .valid_out  (valid_out),
      .out_ready  (out_ready),
      .err_lane   (err_lane)
   );

   always #5 clk_f = ~clk_f;

   task automatic tick();
      @(posedge clk_f);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_round(input logic [7:0] base, input logic [3:0] lv);
      for (int i = 0; i < 4; i++) lane_data[i*32 +: 32] = 32'(base) + 32'(i);
      lane_valid = lv;
   endtask

   task automatic expect_words(input string tag, input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         check({tag, "_data"}, data_out, 32'(base) + 32'(i));
         check({tag, "_valid"}, {31'd0, valid_out}, 32'd1);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset with random inputs
      reset_L    = 1'b0;
      lane_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      lane_valid = 4'($urandom_range(0, 15));
      out_ready  = 1'($urandom_range(0, 1));
      repeat (3) begin
         tick();
         lane_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
         lane_valid = 4'($urandom_range(0, 15));
         out_ready  = 1'($urandom_range(0, 1));
      end
      check("rst_data", data_out, 32'd0);
      check("rst_valid", {31'd0, valid_out}, 32'd0);
      check("rst_err", {31'd0, err_lane}, 32'd0);
      lane_valid = 4'b0000;
      out_ready  = 1'b1;
      reset_L    = 1'b1;
      tick();
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("idle_valid", {31'd0, valid_out}, 32'd0);

      // Full round A
      set_round(8'hA0, 4'b1111);
      tick();
      lane_valid = 4'b0000;
      check("A_latency", {31'd0, valid_out}, 32'd0);
      expect_words("A", 8'hA0, 4);
      tick();
      check("A_end_valid", {31'd0, valid_out}, 32'd0);
      check("A_hold_data", data_out, 32'hA3);

      // Partial B back-to-back with full C
      set_round(8'hB0, 4'b0011);
      tick();
      set_round(8'hC0, 4'b1111);
      tick();
      lane_valid = 4'b0000;
      check("B_data0", data_out, 32'hB0);
      check("B_valid0", {31'd0, valid_out}, 32'd1);
      tick();
      check("B_data1", data_out, 32'hB1);
      expect_words("C", 8'hC0, 4);
      tick();
      check("C_end_valid", {31'd0, valid_out}, 32'd0);

      // Single-lane round
      set_round(8'h30, 4'b0001);
      tick();
      lane_valid = 4'b0000;
      expect_words("K1", 8'h30, 1);
      tick();
      check("K1_end_valid", {31'd0, valid_out}, 32'd0);

      // Non-contiguous valid, then a good round
      set_round(8'h40, 4'b0101);
      tick();
      lane_valid = 4'b0000;
      check("E_err_set", {31'd0, err_lane}, 32'd1);
      tick();
      check("E_no_output", {31'd0, valid_out}, 32'd0);
      set_round(8'h90, 4'b1111);
      tick();
      lane_valid = 4'b0000;
      expect_words("G9", 8'h90, 4);
      tick();
      check("G9_end_valid", {31'd0, valid_out}, 32'd0);
      check("E_err_sticky", {31'd0, err_lane}, 32'd1);

      // Backpressure: D and E accepted, F held off
      out_ready = 1'b0;
      set_round(8'hD0, 4'b1111);
      tick();
      check("BP_ready1", {31'd0, in_ready}, 32'd1);
      set_round(8'hE0, 4'b1111);
      tick();
      check("BP_D0", data_out, 32'hD0);
      check("BP_ready0", {31'd0, in_ready}, 32'd0);
      set_round(8'hF0, 4'b1111);
      tick();
      check("BP_D0_hold", data_out, 32'hD0);
      check("BP_valid_hold", {31'd0, valid_out}, 32'd1);
      tick();
      check("BP_D0_hold2", data_out, 32'hD0);
      check("BP_full", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         logic [31:0] exp_w;
         if (i < 3)      exp_w = 32'hD1 + 32'(i);
         else if (i < 7) exp_w = 32'hE0 + 32'(i - 3);
         else            exp_w = 32'hF0 + 32'(i - 7);
         tick();
         check("BP_stream", data_out, exp_w);
         check("BP_stream_valid", {31'd0, valid_out}, 32'd1);
         if (i == 2) check("BP_ready_after_pop", {31'd0, in_ready}, 32'd1);
         if (i == 3) lane_valid = 4'b0000;
      end
      tick();
      check("BP_end_valid", {31'd0, valid_out}, 32'd0);
      check("BP_err_sticky", {31'd0, err_lane}, 32'd1);

      // Reset mid-stream after D1
      set_round(8'hD0, 4'b1111);
      tick();
      lane_valid = 4'b0000;
      tick();
      check("MR_D0", data_out, 32'hD0);
      tick();
      check("MR_D1", data_out, 32'hD1);
      #2;
      reset_L = 1'b0;
      #1;
      check("MR_async_valid", {31'd0, valid_out}, 32'd0);
      check("MR_async_data", data_out, 32'd0);
      check("MR_async_err", {31'd0, err_lane}, 32'd0);
      check("MR_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      reset_L = 1'b1;
      tick();
      check("MR_flushed", {31'd0, valid_out}, 32'd0);
      set_round(8'h60, 4'b1111);
      tick();
      lane_valid = 4'b0000;
      expect_words("G", 8'h60, 4);
      tick();
      check("G_end_valid", {31'd0, valid_out}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
